// File: rtl/vga_sram_arbiter.sv
// Purpose: single-port SRAM arbiter; scanout reads always win, frame-capture writes fill idle cycles.
// Latency: read data RD_LAT+2 cycles after rd_req; a write is issued 1 cycle after wr_req is sampled.
// Backpressure: reads are never stalled; the writer holds wr_req until wr_ack (at most 1 write per 2 cycles).
//
// Optional build macro: VGA_SRAM_ARB_WR_HOLDOFF_EN -- when defined, writes are only issued during
// blanking (in_display registered one cycle); when undefined, in_display is ignored.
//
// Ports:
//   clk, rst_n            pixel clock, asynchronous active-low reset
//   in_display            active-video indicator from the timing generator
//   rd_req/rd_addr        single-cycle scanout read request (always accepted)
//   rd_valid/rd_data      registered read return, RD_LAT+2 cycles after rd_req
//   wr_req/wr_addr/wr_data  held write request; wr_ack pulses in the cycle the write is issued
//   mem_ce/mem_we/mem_addr/mem_wdata/mem_rdata  synchronous SRAM port
//   wr_starved            sticky: writer waited STARVE_MAX cycles without a grant
module vga_sram_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 12,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_display,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wr_starved
);

  // Wait counter is at least 10 bits and always wide enough to hold STARVE_MAX.
  localparam int CNT_W = ($clog2(STARVE_MAX + 1) > 10) ? $clog2(STARVE_MAX + 1) : 10;
  localparam logic [CNT_W-1:0] STARVE_LIM = STARVE_MAX[CNT_W-1:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic             holdoff;
  logic [RD_LAT:0]  vld_sr;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_inc;
  logic             wait_step;

`ifdef VGA_SRAM_ARB_WR_HOLDOFF_EN
  // Registered copy of in_display: writes wait while the previous cycle was active video.
  logic in_display_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_display_q <= 1'b0;
    end else begin
      in_display_q <= in_display;
    end
  end
  assign holdoff = in_display_q;
`else
  logic unused_in_display;
  assign unused_in_display = in_display;
  assign holdoff           = 1'b0;
`endif

  // Next op: a read always wins; a write is never granted in the cycle its ack is
  // visible, giving the writer one cycle to present the next request.
  always_comb begin
    state_d = S_IDLE;
    if (rd_req) begin
      state_d = S_RD;
    end else if (wr_req && !wr_ack && !holdoff) begin
      state_d = S_WR;
    end
  end

  // State register plus registered memory-side outputs for the op chosen above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mem_ce    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr_ack    <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_ce  <= (state_d != S_IDLE);
      mem_we  <= (state_d == S_WR);
      wr_ack  <= (state_d == S_WR);
      case (state_d)
        S_RD: mem_addr <= rd_addr;
        S_WR: begin
          mem_addr  <= wr_addr;
          mem_wdata <= wr_data;
        end
        default: ;
      endcase
    end
  end

  // Bit k of vld_sr is set k cycles after the read cycle; bit RD_LAT marks the
  // cycle in which mem_rdata carries that read's data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      vld_sr   <= {vld_sr[RD_LAT-1:0], (state_d == S_RD)};
      rd_valid <= vld_sr[RD_LAT];
      if (vld_sr[RD_LAT]) begin
        rd_data <= mem_rdata;
      end
    end
  end

  // Writer starvation: count cycles with a pending request that is not being issued.
  assign wait_step    = wr_req && (state_q != S_WR) && (wait_cnt != STARVE_LIM);
  assign wait_cnt_inc = wait_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt   <= '0;
      wr_starved <= 1'b0;
    end else begin
      if (state_q == S_WR) begin
        wait_cnt <= '0;
      end else if (wait_step) begin
        wait_cnt <= wait_cnt_inc;
        if (wait_cnt_inc == STARVE_LIM) begin
          wr_starved <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_sram_arbiter.sv
module tb_vga_sram_arbiter;

  localparam int ADDR_W     = 19;
  localparam int DATA_W     = 12;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_display;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              mem_ce;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              wr_starved;

  int total = 0;
  int bad   = 0;

  vga_sram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_display(in_display),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .wr_starved(wr_starved)
  );

  always #5 clk = ~clk;

  // Memory content is a fixed function of the address (0x00010 -> 0xABC).
  function automatic logic [DATA_W-1:0] mem_f(input logic [ADDR_W-1:0] a);
    return a[11:0] ^ 12'hAAC;
  endfunction

  // Synchronous SRAM model: a read in cycle k returns data during cycle k+RD_LAT;
  // every other cycle mem_rdata carries random garbage.
  int                cyc = 0;
  logic [DATA_W-1:0] sched_d [8];
  logic [7:0]        sched_v = '0;
  always @(posedge clk) begin
    int s;
    if (mem_ce === 1'b1 && mem_we === 1'b0) begin
      s = (cyc + RD_LAT) % 8;
      sched_d[s] = mem_f(mem_addr);
      sched_v[s] = 1'b1;
    end
    s = (cyc + 1) % 8;
    if (sched_v[s]) begin
      mem_rdata <= sched_d[s];
      sched_v[s] = 1'b0;
    end else begin
      mem_rdata <= DATA_W'($urandom);
    end
    cyc <= cyc + 1;
  end

  task automatic drive_idle();
    rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0; in_display = 1'b0;
  endtask

  // Returns at the sample point of the first cycle after reset release, inputs idle.
  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    total++;
    if ({mem_ce, mem_we, mem_addr, mem_wdata, rd_valid, rd_data, wr_ack, wr_starved} !== '0) begin
      bad++; $display("FAIL reset_init: outputs not all zero (ce=%b we=%b addr=%h starved=%b)", mem_ce, mem_we, mem_addr, wr_starved);
    end
    rst_n = 1'b1;
    // Reads every cycle with a held write: reads in flight and writer starved.
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      rd_req = 1'b1; rd_addr = ADDR_W'($urandom);
      wr_req = 1'b1; wr_addr = ADDR_W'($urandom); wr_data = DATA_W'($urandom);
    end
    @(posedge clk); #1;
    total++;
    if (wr_starved !== 1'b1 || mem_ce !== 1'b1) begin
      bad++; $display("FAIL reset_pre: starved=%b ce=%b want 1 1", wr_starved, mem_ce);
    end
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({mem_ce, mem_we, mem_addr, mem_wdata, rd_valid, rd_data, wr_ack, wr_starved} !== '0) begin
      bad++; $display("FAIL reset_async: outputs not zero (ce=%b addr=%h rd_valid=%b starved=%b)", mem_ce, mem_addr, rd_valid, wr_starved);
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      rd_req = 1'($urandom); wr_req = 1'($urandom); in_display = 1'($urandom);
      total++;
      if ({mem_ce, mem_we, rd_valid, wr_ack, wr_starved} !== '0) begin
        bad++; $display("FAIL reset_hold: ce=%b we=%b vld=%b ack=%b starved=%b want 0", mem_ce, mem_we, rd_valid, wr_ack, wr_starved);
      end
    end
    drive_idle();
    rst_n = 1'b1;
    for (int k = 0; k < RD_LAT + 4; k++) begin
      @(posedge clk); #1;
      total++;
      if (rd_valid !== 1'b0 || wr_ack !== 1'b0 || mem_ce !== 1'b0) begin
        bad++; $display("FAIL reset_flush cyc %0d: vld=%b ack=%b ce=%b want 0 0 0", k, rd_valid, wr_ack, mem_ce);
      end
    end
  endtask

  task automatic test_single_read();
    do_reset();
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      total++;
      if (rd_valid !== (k == 4)) begin
        bad++; $display("FAIL single_read_vld cyc %0d: got %b want %b", k, rd_valid, (k == 4));
      end
      if (k == 1) begin
        total++;
        if (mem_ce !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 19'h00010) begin
          bad++; $display("FAIL single_read_mem: ce=%b we=%b addr=%h want 1 0 00010", mem_ce, mem_we, mem_addr);
        end
      end
      if (k >= 4) begin
        total++;
        if (rd_data !== 12'hABC) begin
          bad++; $display("FAIL single_read_data cyc %0d: got %h want abc", k, rd_data);
        end
      end
      rd_req  = (k == 0);
      rd_addr = (k == 0) ? 19'h00010 : 19'h7FFFF;
    end
  endtask

  task automatic test_collision();
    int acks = 0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (wr_ack === 1'b1) acks++;
      if (k == 1) begin
        total++;
        if (mem_ce !== 1'b1 || mem_we !== 1'b0 || wr_ack !== 1'b0 || mem_addr !== 19'h00030) begin
          bad++; $display("FAIL collision_rd: ce=%b we=%b ack=%b addr=%h want 1 0 0 00030", mem_ce, mem_we, wr_ack, mem_addr);
        end
      end
      if (k == 2) begin
        total++;
        if (mem_we !== 1'b1 || wr_ack !== 1'b1 || mem_addr !== 19'h00020 || mem_wdata !== 12'h5A5) begin
          bad++; $display("FAIL collision_wr: we=%b ack=%b addr=%h wdata=%h want 1 1 00020 5a5", mem_we, wr_ack, mem_addr, mem_wdata);
        end
      end
      rd_req  = (k == 0);
      rd_addr = 19'h00030;
      if (k == 0) begin
        wr_req = 1'b1; wr_addr = 19'h00020; wr_data = 12'h5A5;
      end else if (wr_ack === 1'b1) begin
        wr_req = 1'b0;
      end
    end
    total++;
    if (acks != 1) begin
      bad++; $display("FAIL collision_acks: got %0d want 1", acks);
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] cur_a;
    logic [DATA_W-1:0] cur_d;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      total++;
      if (wr_ack !== (k % 2 == 1)) begin
        bad++; $display("FAIL b2b_ack cyc %0d: got %b want %b", k, wr_ack, (k % 2 == 1));
      end
      if (k % 2 == 1) begin
        total++;
        if (mem_we !== 1'b1 || mem_addr !== cur_a || mem_wdata !== cur_d) begin
          bad++; $display("FAIL b2b_data cyc %0d: we=%b addr=%h data=%h want 1 %h %h", k, mem_we, mem_addr, mem_wdata, cur_a, cur_d);
        end
      end
      if (k == 0 || wr_ack === 1'b1) begin
        cur_a = ADDR_W'($urandom); cur_d = DATA_W'($urandom);
        wr_req = 1'b1; wr_addr = cur_a; wr_data = cur_d;
      end
    end
    wr_req = 1'b0;
  endtask

  task automatic test_streaming();
    int n = 0;
    logic [ADDR_W-1:0] base = 19'h12340;
    do_reset();
    for (int k = 0; k < 648; k++) begin
      @(posedge clk); #1;
      total++;
      if (rd_valid !== (k >= RD_LAT + 2 && k < 640 + RD_LAT + 2)) begin
        bad++; $display("FAIL stream_vld cyc %0d: got %b", k, rd_valid);
      end
      if (rd_valid === 1'b1) begin
        total++;
        if (rd_data !== mem_f(base + ADDR_W'(n))) begin
          bad++; $display("FAIL stream_data #%0d: got %h want %h", n, rd_data, mem_f(base + ADDR_W'(n)));
        end
        n++;
      end
      total++;
      if (mem_we !== (k == 641)) begin
        bad++; $display("FAIL stream_we cyc %0d: got %b want %b", k, mem_we, (k == 641));
      end
      rd_req  = (k < 640);
      rd_addr = base + ADDR_W'(k);
      if (k == 0) begin
        wr_req = 1'b1; wr_addr = 19'h00055; wr_data = 12'h123;
      end else if (wr_ack === 1'b1) begin
        wr_req = 1'b0;
      end
    end
    total++;
    if (n != 640) begin
      bad++; $display("FAIL stream_count: got %0d want 640", n);
    end
  endtask

  task automatic test_holdoff();
`ifdef VGA_SRAM_ARB_WR_HOLDOFF_EN
    localparam int ACK_CYC = 102;
`else
    localparam int ACK_CYC = 1;
`endif
    do_reset();
    in_display = 1'b1;
    for (int k = 0; k < ACK_CYC + 4; k++) begin
      @(posedge clk); #1;
      total++;
      if (wr_ack !== (k == ACK_CYC) || mem_we !== (k == ACK_CYC)) begin
        bad++; $display("FAIL holdoff cyc %0d: ack=%b we=%b want %b", k, wr_ack, mem_we, (k == ACK_CYC));
      end
      in_display = (k < 100);
      if (k == 0) begin
        wr_req = 1'b1; wr_addr = 19'h00777; wr_data = 12'h0F0;
      end else if (wr_ack === 1'b1) begin
        wr_req = 1'b0;
      end
    end
    in_display = 1'b0;
  endtask

  task automatic test_starvation();
    do_reset();
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      total++;
      if (wr_starved !== (k >= STARVE_MAX)) begin
        bad++; $display("FAIL starve_flag cyc %0d: got %b want %b", k, wr_starved, (k >= STARVE_MAX));
      end
      total++;
      if (wr_ack !== (k == 21)) begin
        bad++; $display("FAIL starve_ack cyc %0d: got %b want %b", k, wr_ack, (k == 21));
      end
      rd_req = (k < 20); rd_addr = ADDR_W'($urandom);
      if (k == 0) begin
        wr_req = 1'b1; wr_addr = 19'h00abc; wr_data = 12'h321;
      end else if (wr_ack === 1'b1) begin
        wr_req = 1'b0;
      end
    end
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (wr_starved !== 1'b0) begin
      bad++; $display("FAIL starve_clear: got %b want 0", wr_starved);
    end
    drive_idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Random traffic against a rule-level model: reads return f(addr) exactly
  // RD_LAT+2 cycles later; a write is issued the cycle after a pending request
  // when that cycle had no read, no visible ack and (optionally) no active video.
  task automatic test_random();
    int                due_q[$];
    logic [DATA_W-1:0] dat_q[$];
    logic              p_rd, p_wr, p_ack, p_hold, disp_prev, starved;
    logic [ADDR_W-1:0] p_rd_addr, p_wr_addr;
    logic [DATA_W-1:0] p_wr_data;
    int                waited;
    do_reset();
    p_rd = 1'b0; p_wr = 1'b0; p_ack = 1'b0; p_hold = 1'b0; disp_prev = 1'b0;
    starved = 1'b0; waited = 0; p_rd_addr = '0; p_wr_addr = '0; p_wr_data = '0;
    for (int k = 0; k < 1500; k++) begin
      logic e_rd, e_wr, e_vld;
      logic [DATA_W-1:0] e_dat;
      @(posedge clk); #1;
      if (p_ack) waited = 0;
      else if (p_wr && waited < STARVE_MAX) waited++;
      if (waited == STARVE_MAX) starved = 1'b1;
      e_rd  = p_rd;
      e_wr  = !p_rd && p_wr && !p_ack && !p_hold;
      e_vld = (due_q.size() > 0) && (due_q[0] == k);
      e_dat = '0;
      if (e_vld) begin
        e_dat = dat_q[0];
        void'(due_q.pop_front());
        void'(dat_q.pop_front());
      end
      total++;
      if (mem_ce !== (e_rd || e_wr) || mem_we !== e_wr || wr_ack !== e_wr) begin
        bad++; $display("FAIL rand_op cyc %0d: ce=%b we=%b ack=%b want %b %b %b", k, mem_ce, mem_we, wr_ack, e_rd || e_wr, e_wr, e_wr);
      end
      total++;
      if (rd_valid !== e_vld || (e_vld && rd_data !== e_dat)) begin
        bad++; $display("FAIL rand_rd cyc %0d: vld=%b data=%h want %b %h", k, rd_valid, rd_data, e_vld, e_dat);
      end
      if (e_rd) begin
        total++;
        if (mem_addr !== p_rd_addr) begin
          bad++; $display("FAIL rand_rd_addr cyc %0d: got %h want %h", k, mem_addr, p_rd_addr);
        end
      end
      if (e_wr) begin
        total++;
        if (mem_addr !== p_wr_addr || mem_wdata !== p_wr_data) begin
          bad++; $display("FAIL rand_wr cyc %0d: addr=%h data=%h want %h %h", k, mem_addr, mem_wdata, p_wr_addr, p_wr_data);
        end
      end
      total++;
      if (wr_starved !== starved) begin
        bad++; $display("FAIL rand_starved cyc %0d: got %b want %b", k, wr_starved, starved);
      end
      // Drive cycle k.
      rd_req  = ($urandom_range(0, 99) < 45);
      rd_addr = ADDR_W'($urandom);
      in_display = ($urandom_range(0, 99) < 40);
      if (!wr_req || wr_ack === 1'b1) begin
        wr_req  = ($urandom_range(0, 9) < 6);
        wr_addr = ADDR_W'($urandom);
        wr_data = DATA_W'($urandom);
      end
      if (rd_req) begin
        due_q.push_back(k + RD_LAT + 2);
        dat_q.push_back(mem_f(rd_addr));
      end
`ifdef VGA_SRAM_ARB_WR_HOLDOFF_EN
      p_hold = disp_prev;
`else
      p_hold = 1'b0;
`endif
      disp_prev = in_display;
      p_rd = rd_req; p_rd_addr = rd_addr;
      p_wr = wr_req; p_wr_addr = wr_addr; p_wr_data = wr_data;
      p_ack = e_wr;
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_single_read();
    test_collision();
    test_back_to_back();
    test_streaming();
    test_holdoff();
    test_starvation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
